// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares the single-port VRAM between the display fetch path
//            (absolute priority) and a CPU req/ack load/store port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 16,
  parameter bit CPU_BLANK_ONLY = 1'b0
) (
  input  logic              pixelClock,
  input  logic              reset,
  input  logic              bright,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic [DATA_W-1:0] dispData,
  output logic              dispValid,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_ACK = 3'd1,
    ST_RD1    = 3'd2,
    ST_RD2    = 3'd3,
    ST_RD_ACK = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_cpu_gnt;
  logic                w_ack_next;
  logic                w_rd_capture;

  logic [ADDR_W-1:0]   r_memAddr;
  logic                r_memWe;
  logic [DATA_W-1:0]   r_memWdata;
  logic [1:0]          r_disp_pipe;
  logic [DATA_W-1:0]   r_dispData;
  logic                r_dispValid;
  logic [DATA_W-1:0]   r_cpuRdata;
  logic                r_cpuAck;

  // The display owns the slot whenever it asks; the CPU only gets leftovers.
  always_comb begin
    w_next       = r_state;
    w_cpu_gnt    = 1'b0;
    w_ack_next   = 1'b0;
    w_rd_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!dispReq && cpuReq && (!CPU_BLANK_ONLY || !bright)) begin
          w_cpu_gnt = 1'b1;
          if (cpuWe) begin
            w_next     = ST_WR_ACK;
            w_ack_next = 1'b1;
          end else begin
            w_next = ST_RD1;
          end
        end
      end
      ST_WR_ACK: w_next = ST_IDLE;
      ST_RD1:    w_next = ST_RD2;
      ST_RD2: begin
        w_next       = ST_RD_ACK;
        w_ack_next   = 1'b1;
        w_rd_capture = 1'b1;
      end
      ST_RD_ACK: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_memAddr   <= '0;
      r_memWe     <= 1'b0;
      r_memWdata  <= '0;
      r_disp_pipe <= 2'b00;
      r_dispData  <= '0;
      r_dispValid <= 1'b0;
      r_cpuRdata  <= '0;
      r_cpuAck    <= 1'b0;
    end else begin
      r_state <= w_next;

      // Idle slots keep the last address so the RAM sees no spurious toggling.
      if (dispReq) begin
        r_memAddr <= dispAddr;
        r_memWe   <= 1'b0;
      end else if (w_cpu_gnt) begin
        r_memAddr  <= cpuAddr;
        r_memWe    <= cpuWe;
        r_memWdata <= cpuWdata;
      end else begin
        r_memWe <= 1'b0;
      end

      r_disp_pipe <= {r_disp_pipe[0], dispReq};
      r_dispValid <= r_disp_pipe[1];
      if (r_disp_pipe[1]) begin
        r_dispData <= memRdata;
      end

      r_cpuAck <= w_ack_next;
      if (w_rd_capture) begin
        r_cpuRdata <= memRdata;
      end
    end
  end

  assign memAddr   = r_memAddr;
  assign memWe     = r_memWe;
  assign memWdata  = r_memWdata;
  assign dispData  = r_dispData;
  assign dispValid = r_dispValid;
  assign cpuRdata  = r_cpuRdata;
  assign cpuAck    = r_cpuAck;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Scoreboard bench for vram_arbiter; instance 0 free-running CPU,
//            instance 1 blank-only CPU, sharing display/bright stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;

  typedef struct { int cyc; logic [DW-1:0] data; } dexp_t;
  typedef struct { int cyc; logic we; logic [DW-1:0] data; } aexp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic we; logic [DW-1:0] data; } mexp_t;

  logic          clk;
  logic          reset;
  logic          bright;
  logic          dispReq;
  logic [AW-1:0] dispAddr;
  logic [1:0]    cpuReq;
  logic [1:0]    cpuWe;
  logic [AW-1:0] cpuAddr  [2];
  logic [DW-1:0] cpuWdata [2];
  logic [DW-1:0] dispData [2];
  logic [1:0]    dispValid;
  logic [DW-1:0] cpuRdata [2];
  logic [1:0]    cpuAck;
  logic [AW-1:0] memAddr  [2];
  logic [1:0]    memWe;
  logic [DW-1:0] memWdata [2];
  logic [DW-1:0] memRdata [2];

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_BLANK_ONLY(1'b0)) u_dut0 (
    .pixelClock(clk), .reset(reset), .bright(bright),
    .dispReq(dispReq), .dispAddr(dispAddr), .dispData(dispData[0]), .dispValid(dispValid[0]),
    .cpuReq(cpuReq[0]), .cpuWe(cpuWe[0]), .cpuAddr(cpuAddr[0]), .cpuWdata(cpuWdata[0]),
    .cpuRdata(cpuRdata[0]), .cpuAck(cpuAck[0]),
    .memAddr(memAddr[0]), .memWe(memWe[0]), .memWdata(memWdata[0]), .memRdata(memRdata[0])
  );

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_BLANK_ONLY(1'b1)) u_dut1 (
    .pixelClock(clk), .reset(reset), .bright(bright),
    .dispReq(dispReq), .dispAddr(dispAddr), .dispData(dispData[1]), .dispValid(dispValid[1]),
    .cpuReq(cpuReq[1]), .cpuWe(cpuWe[1]), .cpuAddr(cpuAddr[1]), .cpuWdata(cpuWdata[1]),
    .cpuRdata(cpuRdata[1]), .cpuAck(cpuAck[1]),
    .memAddr(memAddr[1]), .memWe(memWe[1]), .memWdata(memWdata[1]), .memRdata(memRdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: registered read; unwritten words read back as addr+0x100.
  logic [DW-1:0] vram    [2][1<<AW];
  bit            vram_wr [2][1<<AW];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (memWe[k]) begin
        vram[k][memAddr[k]]    <= memWdata[k];
        vram_wr[k][memAddr[k]] <= 1'b1;
      end
      memRdata[k] <= vram_wr[k][memAddr[k]] ? vram[k][memAddr[k]]
                                            : ({2'b00, memAddr[k]} + 16'h0100);
    end
  end

  // Reference memory contents as the bench expects them to be.
  logic [DW-1:0] refmem [2][1<<AW];
  bit            ref_wr [2][1<<AW];

  function automatic logic [DW-1:0] ref_rd(input int k, input logic [AW-1:0] a);
    return ref_wr[k][a] ? refmem[k][a] : ({2'b00, a} + 16'h0100);
  endfunction

  dexp_t dq [2][$];
  aexp_t aq [2][$];
  mexp_t mq [2][$];

  int            cycle;
  int            nchk;
  int            nerr;
  bit            mon_en;
  logic [AW-1:0] last_addr [2];

  bit            act    [2];
  bit            gnt    [2];
  int            ack_at [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cycle, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // One bench cycle: drive shared display/bright inputs, and let each CPU
  // driver start a transaction if it is free. Expected responses are queued
  // from the arbitration rules: display first, CPU only when free and allowed.
  task automatic step(input bit d, input logic [AW-1:0] da, input bit b,
                      input bit st, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    tick();
    dispReq  = d;
    dispAddr = da;
    bright   = b;
    for (int k = 0; k < 2; k++) begin
      if (d) begin
        dq[k].push_back('{cyc: cycle + 3, data: ref_rd(k, da)});
        mq[k].push_back('{cyc: cycle + 1, addr: da, we: 1'b0, data: '0});
      end
      if (act[k] && gnt[k] && cycle > ack_at[k]) begin
        act[k]    = 1'b0;
        cpuReq[k] = 1'b0;
      end
      if (st && !act[k]) begin
        act[k]      = 1'b1;
        gnt[k]      = 1'b0;
        cpuReq[k]   = 1'b1;
        cpuWe[k]    = we;
        cpuAddr[k]  = a;
        cpuWdata[k] = wd;
      end
      if (act[k] && !gnt[k] && !d && (k == 0 || !b)) begin
        gnt[k]    = 1'b1;
        ack_at[k] = cycle + (cpuWe[k] ? 1 : 3);
        aq[k].push_back('{cyc: ack_at[k], we: cpuWe[k],
                          data: cpuWe[k] ? 16'h0 : ref_rd(k, cpuAddr[k])});
        mq[k].push_back('{cyc: cycle + 1, addr: cpuAddr[k], we: cpuWe[k], data: cpuWdata[k]});
        if (cpuWe[k]) begin
          refmem[k][cpuAddr[k]] = cpuWdata[k];
          ref_wr[k][cpuAddr[k]] = 1'b1;
        end
      end
    end
  endtask

  // Monitor: every cycle each output is compared with what the queues say
  // should (or should not) appear in that cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        bit de, ae, me;
        de = dq[k].size() > 0 && dq[k][0].cyc == cycle;
        chk($sformatf("dispValid%0d", k), {31'b0, dispValid[k]}, {31'b0, de});
        if (de) begin
          chk($sformatf("dispData%0d", k), {16'b0, dispData[k]}, {16'b0, dq[k][0].data});
          void'(dq[k].pop_front());
        end
        ae = aq[k].size() > 0 && aq[k][0].cyc == cycle;
        chk($sformatf("cpuAck%0d", k), {31'b0, cpuAck[k]}, {31'b0, ae});
        if (ae) begin
          if (!aq[k][0].we)
            chk($sformatf("cpuRdata%0d", k), {16'b0, cpuRdata[k]}, {16'b0, aq[k][0].data});
          void'(aq[k].pop_front());
        end
        me = mq[k].size() > 0 && mq[k][0].cyc == cycle;
        if (me) begin
          chk($sformatf("memAddr%0d", k), {18'b0, memAddr[k]}, {18'b0, mq[k][0].addr});
          chk($sformatf("memWe%0d", k), {31'b0, memWe[k]}, {31'b0, mq[k][0].we});
          if (mq[k][0].we)
            chk($sformatf("memWdata%0d", k), {16'b0, memWdata[k]}, {16'b0, mq[k][0].data});
          last_addr[k] = mq[k][0].addr;
          void'(mq[k].pop_front());
        end else begin
          chk($sformatf("idle_memWe%0d", k), {31'b0, memWe[k]}, 32'd0);
          chk($sformatf("idle_memAddr%0d", k), {18'b0, memAddr[k]}, {18'b0, last_addr[k]});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            b;
    bit            w;
    logic [AW-1:0] a;
    cycle    = 0;
    nchk     = 0;
    nerr     = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    bright   = 1'b0;
    dispReq  = 1'b0;
    dispAddr = '0;
    cpuReq   = 2'b00;
    cpuWe    = 2'b00;
    for (int k = 0; k < 2; k++) begin
      cpuAddr[k]   = '0;
      cpuWdata[k]  = '0;
      act[k]       = 1'b0;
      gnt[k]       = 1'b0;
      ack_at[k]    = 0;
      last_addr[k] = '0;
    end

    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_memAddr",   {18'b0, memAddr[k]},  32'd0);
      chk("rst_memWe",     {31'b0, memWe[k]},    32'd0);
      chk("rst_memWdata",  {16'b0, memWdata[k]}, 32'd0);
      chk("rst_dispData",  {16'b0, dispData[k]}, 32'd0);
      chk("rst_dispValid", {31'b0, dispValid[k]}, 32'd0);
      chk("rst_cpuRdata",  {16'b0, cpuRdata[k]}, 32'd0);
      chk("rst_cpuAck",    {31'b0, cpuAck[k]},   32'd0);
    end

    // Reset landing in RD2 with a display read in flight.
    tick();
    reset  = 1'b0;
    cpuReq = 2'b11;
    cpuWe  = 2'b00;
    for (int k = 0; k < 2; k++) cpuAddr[k] = 14'h0033;
    tick();
    dispReq  = 1'b1;
    dispAddr = 14'h0040;
    tick();
    dispReq = 1'b0;
    reset   = 1'b1;
    tick();
    reset  = 1'b0;
    cpuReq = 2'b00;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("midrst_cpuAck",    {31'b0, cpuAck[k]},    32'd0);
        chk("midrst_memWe",     {31'b0, memWe[k]},     32'd0);
        chk("midrst_dispValid", {31'b0, dispValid[k]}, 32'd0);
      end
      tick();
    end

    for (int k = 0; k < 2; k++) last_addr[k] = memAddr[k];
    chk("post_rst_addr0", {18'b0, memAddr[0]}, 32'd0);
    mon_en = 1'b1;

    // Eight back-to-back display reads.
    for (int i = 0; i < 8; i++) step(1'b1, 14'h0010 + 14'(i), 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Single CPU write, quiet display.
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 14'h0200, 16'hBEEF);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

    // CPU read blocked by five display reads.
    step(1'b1, 14'h0020, 1'b0, 1'b1, 1'b0, 14'h0033, '0);
    for (int i = 1; i < 5; i++) step(1'b1, 14'h0020 + 14'(i), 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (6) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Read-back of the earlier write, then a request held off by bright.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 14'h0200, '0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 14'h0123, '0);
    repeat (19) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
    repeat (6) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

    // cpuReq held high across three writes.
    for (int i = 0; i < 6; i++)
      step(1'b0, '0, 1'b0, 1'b1, 1'b1, 14'h2100 + 14'(i), 16'h1000 + 16'(i));
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic.
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) b = ~b;
      w = 1'($urandom_range(0, 1));
      if (w || $urandom_range(0, 1) == 1) a = 14'h2000 | 14'($urandom_range(0, 63));
      else                                a = 14'($urandom_range(0, 14'h1FFF));
      step($urandom_range(0, 2) == 0, 14'($urandom_range(0, 14'h1FFF)), b,
           1'($urandom_range(0, 1)), w, a, 16'($urandom));
    end
    repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

    mon_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("drain_disp", dq[k].size(), 32'd0);
      chk("drain_ack",  aq[k].size(), 32'd0);
      chk("drain_mem",  mq[k].size(), 32'd0);
      chk("drain_req",  {31'b0, cpuReq[k]}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
